// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM-subset controller.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
    } state_t;

    // ALUControl codes (low three bits; wider ALUControl is zero-extended)
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;
    localparam logic [2:0] ALU_SHF = 3'b101;

    // DP command field Funct[4:1]
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    // Condition codes
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // ImmSrc / ResultSrc encodings
    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    typedef struct packed {
        logic [2:0] op;
        logic       shift;    // route shifter result
        logic       nowrite;  // compare: flags only
        logic       arith;    // C,V are meaningful
        logic       legal;
    } aludec_t;

    function automatic aludec_t alu_decode(input logic [3:0] cmd);
        aludec_t d;
        d       = '0;
        d.op    = ALU_ADD;
        d.legal = 1'b1;
        case (cmd)
            CMD_ADD: begin d.op = ALU_ADD; d.arith = 1'b1; end
            CMD_SUB: begin d.op = ALU_SUB; d.arith = 1'b1; end
            CMD_CMP: begin d.op = ALU_SUB; d.arith = 1'b1; d.nowrite = 1'b1; end
            CMD_AND: d.op = ALU_AND;
            CMD_ORR: d.op = ALU_ORR;
            CMD_EOR: d.op = ALU_EOR;
            CMD_MOV: begin d.op = ALU_SHF; d.shift = 1'b1; end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

    function automatic logic [1:0] imm_for(input logic [1:0] op);
        case (op)
            2'b01:   return IMM_MEM;
            2'b10:   return IMM_BR;
            default: return IMM_DP;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_cond_check.sv
// Condition evaluation against registered NZCV; 1111 never executes.
module cond_check
    import ctrl_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n, z, c, v;
    assign {n, z, c, v} = Flags;

    // ARM condition table
    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = (n == v);
            COND_LT: CondEx = (n != v);
            COND_GT: CondEx = ~z & (n == v);
            COND_LE: CondEx = z | (n != v);
            COND_AL: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle controller: FSM, memory wait counter and NZCV flags register.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int ALUW    = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      Cond,
    input  logic [1:0]      Op,
    input  logic [5:0]      Funct,
    input  logic [3:0]      Rd,
    input  logic [3:0]      ALUFlags,
    output logic            PCWrite,
    output logic            IRWrite,
    output logic            RegW,
    output logic            MemW,
    output logic            AdrSrc,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      ResultSrc,
    output logic [1:0]      ImmSrc,
    output logic [1:0]      RegSrc,
    output logic [ALUW-1:0] ALUControl,
    output logic            Shift,
    output logic            Illegal,
    output logic [3:0]      Flags
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [3:0]    flags_q;
    logic          cond_ex;
    aludec_t       dec;
    logic          wait_st, cnt_last, bad_instr, is_exec, rd_pc;

    assign dec       = alu_decode(Funct[4:1]);
    assign wait_st   = (state == FETCH) || (state == MEMRD);
    assign cnt_last  = (cnt == CW'(MEM_LAT - 1));
    assign bad_instr = (Op == 2'b11) || (Op == 2'b00 && !dec.legal);
    assign is_exec   = (state == EXECR) || (state == EXECI);
    assign rd_pc     = (Rd == 4'hF);
    assign Flags     = flags_q;

    cond_check u_cond (
        .Cond   (Cond),
        .Flags  (flags_q),
        .CondEx (cond_ex)
    );

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_nx;
    end

    // wait counter: counts cycles spent in a memory-occupying state
    always_ff @(posedge clk) begin
        if (reset || !wait_st || cnt_last) cnt <= '0;
        else                               cnt <= cnt + CW'(1);
    end

    // flags register: N,Z from any S-suffixed DP op, C,V only from arithmetic
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else if (is_exec && Funct[0] && dec.legal) begin
            flags_q[3:2] <= ALUFlags[3:2];
            if (dec.arith) flags_q[1:0] <= ALUFlags[1:0];
        end
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            FETCH:  if (cnt_last) state_nx = DECODE;
            DECODE: begin
                if (!cond_ex || bad_instr) state_nx = FETCH;
                else if (Op == 2'b00)      state_nx = Funct[5] ? EXECI : EXECR;
                else if (Op == 2'b01)      state_nx = MEMADR;
                else                       state_nx = BRANCH;
            end
            MEMADR: state_nx = Funct[0] ? MEMRD : MEMWR;
            MEMRD:  if (cnt_last) state_nx = MEMWB;
            MEMWB:  state_nx = FETCH;
            MEMWR:  state_nx = FETCH;
            EXECR:  state_nx = ALUWB;
            EXECI:  state_nx = ALUWB;
            ALUWB:  state_nx = FETCH;
            BRANCH: state_nx = FETCH;
            default: state_nx = FETCH;
        endcase
    end

    // output decode; write enables are suppressed while reset is high
    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        RegW       = 1'b0;
        MemW       = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = RES_ALUOUT;
        ImmSrc     = IMM_DP;
        RegSrc     = 2'b00;
        ALUControl = ALUW'(ALU_ADD);
        Shift      = 1'b0;
        Illegal    = 1'b0;
        case (state)
            FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = RES_ALURES;
                IRWrite   = cnt_last;
                PCWrite   = cnt_last;
            end
            DECODE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ImmSrc  = imm_for(Op);
                RegSrc  = {(Op == 2'b01) && !Funct[0], Op == 2'b10};
                Illegal = cond_ex && bad_instr;
            end
            MEMADR: begin
                ALUSrcB = 2'b01;
                ImmSrc  = IMM_MEM;
            end
            MEMRD:  AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = RES_DATA;
                RegW      = !rd_pc;
                PCWrite   = rd_pc;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
                RegSrc = 2'b10;
            end
            EXECR: begin
                ALUControl = ALUW'(dec.op);
                Shift      = dec.shift;
            end
            EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = ALUW'(dec.op);
                Shift      = dec.shift;
            end
            ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegW      = !dec.nowrite && !rd_pc;
                PCWrite   = !dec.nowrite && rd_pc;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = RES_ALURES;
                PCWrite   = 1'b1;
                ImmSrc    = IMM_BR;
                RegSrc    = 2'b01;
            end
            default: ;
        endcase
        if (reset) begin
            PCWrite = 1'b0;
            IRWrite = 1'b0;
            RegW    = 1'b0;
            MemW    = 1'b0;
            Illegal = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench: dut_a runs with MEM_LAT=1, dut_b with MEM_LAT=3.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [3:0] Cond, Rd, ALUFlags;
    logic [1:0] Op;
    logic [5:0] Funct;

    logic       PCWrite_a, IRWrite_a, RegW_a, MemW_a, AdrSrc_a, ALUSrcA_a, Shift_a, Illegal_a;
    logic [1:0] ALUSrcB_a, ResultSrc_a, ImmSrc_a, RegSrc_a;
    logic [2:0] ALUControl_a;
    logic [3:0] Flags_a;
    logic       PCWrite_b, IRWrite_b, RegW_b, MemW_b, AdrSrc_b, ALUSrcA_b, Shift_b, Illegal_b;
    logic [1:0] ALUSrcB_b, ResultSrc_b, ImmSrc_b, RegSrc_b;
    logic [2:0] ALUControl_b;
    logic [3:0] Flags_b;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_LAT(1), .ALUW(3)) dut_a (
        .clk(clk), .reset(rst_a), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .PCWrite(PCWrite_a), .IRWrite(IRWrite_a), .RegW(RegW_a),
        .MemW(MemW_a), .AdrSrc(AdrSrc_a), .ALUSrcA(ALUSrcA_a), .ALUSrcB(ALUSrcB_a),
        .ResultSrc(ResultSrc_a), .ImmSrc(ImmSrc_a), .RegSrc(RegSrc_a),
        .ALUControl(ALUControl_a), .Shift(Shift_a), .Illegal(Illegal_a), .Flags(Flags_a)
    );

    multicycle_ctrl #(.MEM_LAT(3), .ALUW(3)) dut_b (
        .clk(clk), .reset(rst_b), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .PCWrite(PCWrite_b), .IRWrite(IRWrite_b), .RegW(RegW_b),
        .MemW(MemW_b), .AdrSrc(AdrSrc_b), .ALUSrcA(ALUSrcA_b), .ALUSrcB(ALUSrcB_b),
        .ResultSrc(ResultSrc_b), .ImmSrc(ImmSrc_b), .RegSrc(RegSrc_b),
        .ALUControl(ALUControl_b), .Shift(Shift_b), .Illegal(Illegal_b), .Flags(Flags_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic setins(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f, input logic [3:0] r);
        Cond  = c;
        Op    = o;
        Funct = f;
        Rd    = r;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        ALUFlags = 4'b0000;
        setins(4'hE, 2'b00, 6'b000000, 4'd0);

        // reset held three cycles
        repeat (3) tick;
        chk("rst_en",    8'({PCWrite_a, IRWrite_a, RegW_a, MemW_a, Illegal_a}), 8'd0);
        chk("rst_flags", 8'(Flags_a), 8'd0);
        chk("rst_fetch", 8'({ALUSrcA_a, ALUSrcB_a, ResultSrc_a}), 8'b11010);

        // ADD R1,R2,R3 (L=1): FETCH, DECODE, EXECR, ALUWB
        setins(4'hE, 2'b00, 6'b001000, 4'd1);
        rst_a = 1'b0;
        #1;
        chk("add_c1", 8'({IRWrite_a, PCWrite_a, RegW_a}), 8'b110);
        tick;
        chk("add_c2", 8'({IRWrite_a, PCWrite_a, RegW_a, ALUSrcA_a, ALUSrcB_a}), 8'b00110);
        tick;
        chk("add_c3", 8'({RegW_a, ALUSrcA_a, ALUSrcB_a, ALUControl_a}), 8'b0000000);
        tick;
        chk("add_c4", 8'({RegW_a, PCWrite_a, ResultSrc_a}), 8'b1000);
        tick;
        chk("add_next",  8'({IRWrite_a, RegW_a}), 8'b10);
        chk("add_flags", 8'(Flags_a), 8'd0);

        // SUBS R0,R1,R2 with ALU reporting Z,C
        setins(4'hE, 2'b00, 6'b000101, 4'd0);
        tick;
        tick;
        ALUFlags = 4'b0110;
        #1;
        chk("subs_alu",   8'(ALUControl_a), 8'b001);
        chk("subs_pre",   8'(Flags_a), 8'd0);
        tick;
        chk("subs_flags", 8'(Flags_a), 8'b0110);
        ALUFlags = 4'b1001;
        tick;
        chk("subs_hold",  8'(Flags_a), 8'b0110);

        // BEQ taken
        setins(4'b0000, 2'b10, 6'b100000, 4'd0);
        tick;
        chk("beq_dec", 8'({RegSrc_a, ImmSrc_a, Illegal_a}), 8'b01100);
        tick;
        chk("beq_br",  8'({PCWrite_a, ImmSrc_a, ResultSrc_a, ALUSrcA_a, ALUSrcB_a}), 8'b11010001);
        tick;

        // BNE not taken: DECODE straight back to FETCH
        setins(4'b0001, 2'b10, 6'b100000, 4'd0);
        tick;
        chk("bne_dec",  8'({PCWrite_a, Illegal_a}), 8'b00);
        tick;
        chk("bne_skip", 8'({IRWrite_a, PCWrite_a, ALUSrcB_a, ResultSrc_a}), 8'b111010);

        // ANDS: N,Z from ALU, C,V kept
        setins(4'hE, 2'b00, 6'b000001, 4'd3);
        tick;
        tick;
        ALUFlags = 4'b1011;
        #1;
        chk("ands_alu",   8'(ALUControl_a), 8'b010);
        tick;
        chk("ands_flags", 8'(Flags_a), 8'b1010);
        tick;

        // STR R1,[R2,#4]
        setins(4'hE, 2'b01, 6'b011000, 4'd1);
        tick;
        chk("str_dec",  8'({RegSrc_a, ImmSrc_a}), 8'b1001);
        tick;
        chk("str_adr",  8'({MemW_a, ALUSrcA_a, ALUSrcB_a, ImmSrc_a}), 8'b000101);
        tick;
        chk("str_wr",   8'({MemW_a, AdrSrc_a, RegSrc_a, RegW_a}), 8'b11100);
        tick;
        chk("str_done", 8'({MemW_a, IRWrite_a}), 8'b01);

        // ADD PC,...: writeback goes to PC
        setins(4'hE, 2'b00, 6'b001000, 4'hF);
        tick;
        tick;
        tick;
        chk("addpc_wb", 8'({PCWrite_a, RegW_a}), 8'b10);
        tick;

        // unimplemented DP command
        setins(4'hE, 2'b00, 6'b001110, 4'd0);
        tick;
        chk("ill_dp",      8'(Illegal_a), 8'b1);
        tick;
        chk("ill_dp_next", 8'({Illegal_a, IRWrite_a}), 8'b01);

        // Op=11
        setins(4'hE, 2'b11, 6'b000000, 4'd0);
        tick;
        chk("ill_op",      8'(Illegal_a), 8'b1);
        tick;
        chk("ill_op_next", 8'({Illegal_a, IRWrite_a}), 8'b01);

        // Cond=1111 never executes, so even Op=11 raises nothing
        setins(4'hF, 2'b11, 6'b000000, 4'd0);
        tick;
        chk("nv_dec",  8'(Illegal_a), 8'b0);
        tick;
        chk("nv_next", 8'(IRWrite_a), 8'b1);

        // MOVS immediate via shifter: only N,Z update (1010 -> 0110)
        setins(4'hE, 2'b00, 6'b111011, 4'd4);
        tick;
        tick;
        ALUFlags = 4'b0111;
        #1;
        chk("mov_exec",  8'({ALUControl_a, Shift_a, ALUSrcB_a}), 8'b101101);
        tick;
        chk("mov_flags", 8'(Flags_a), 8'b0110);
        chk("mov_wb",    8'(RegW_a), 8'b1);
        tick;

        // GT fails with Z=1: skipped after DECODE
        setins(4'b1100, 2'b00, 6'b001000, 4'd1);
        tick;
        tick;
        chk("gt_skip", 8'({IRWrite_a, RegW_a}), 8'b10);

        // ---- MEM_LAT=3: LDR takes 9 cycles
        rst_a = 1'b1;
        ALUFlags = 4'b0000;
        setins(4'hE, 2'b01, 6'b011001, 4'd2);
        rst_b = 1'b0;
        #1;
        chk("ldr_c1", 8'({IRWrite_b, PCWrite_b}), 8'b00);
        tick;
        chk("ldr_c2", 8'({IRWrite_b, PCWrite_b}), 8'b00);
        tick;
        chk("ldr_c3", 8'({IRWrite_b, PCWrite_b}), 8'b11);
        tick;
        chk("ldr_dec", 8'({ALUSrcA_b, ALUSrcB_b, IRWrite_b}), 8'b1100);
        tick;
        chk("ldr_adr", 8'({AdrSrc_b, ALUSrcB_b}), 8'b001);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("ldr_rd", 8'({AdrSrc_b, RegW_b}), 8'b10);
        end
        tick;
        chk("ldr_wb",   8'({RegW_b, ResultSrc_b}), 8'b101);
        tick;
        chk("ldr_done", 8'({AdrSrc_b, RegW_b, IRWrite_b, ResultSrc_b}), 8'b00010);

        // ANDS on dut_b to make Flags non-zero
        setins(4'hE, 2'b00, 6'b000001, 4'd3);
        tick;
        tick;
        tick;
        tick;
        ALUFlags = 4'b0100;
        tick;
        chk("b_flags", 8'(Flags_b), 8'b0100);
        ALUFlags = 4'b0000;
        tick;

        // LDR aborted by reset in its second MEMRD cycle
        setins(4'hE, 2'b01, 6'b011001, 4'd2);
        tick;
        tick;
        tick;
        tick;
        tick;
        tick;
        rst_b = 1'b1;
        #1;
        chk("rst_mid_en", 8'({PCWrite_b, IRWrite_b, RegW_b, MemW_b, Illegal_b}), 8'd0);
        tick;
        rst_b = 1'b0;
        #1;
        chk("rst_mid_flags", 8'(Flags_b), 8'd0);
        chk("rst_mid_fetch", 8'({AdrSrc_b, ALUSrcB_b, ResultSrc_b, IRWrite_b, RegW_b, MemW_b}), 8'b01010000);
        tick;
        tick;
        chk("rst_mid_c3", 8'(IRWrite_b), 8'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised control unit for the multicycle ARM-subset datapath: it replaces the single-cycle combinational decoder with a state machine that sequences fetch, decode, execute, memory and writeback over several cycles. It adds conditional execution against an internal NZCV flags register, a configurable memory wait-state counter and a wider ALU opcode set. The block sits between the instruction register and the shared datapath (PC, single memory port, register file, ALU).

## Interface
Parameters:
- MEM_LAT, 1, cycles a memory access occupies (≥1); applies to FETCH and MEMRD.
- ALUW, 3, ALUControl width (≥3).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- Cond  in  4  instr[31:28]
- Op  in  2  instr[27:26]
- Funct  in  6  instr[25:20]
- Rd  in  4  instr[15:12]
- ALUFlags  in  4  NZCV from ALU, current cycle
- PCWrite, IRWrite, RegW, MemW, AdrSrc, ALUSrcA  out  1 each  datapath enables and selects
- ALUSrcB, ResultSrc, ImmSrc, RegSrc  out  2 each  mux selects
- ALUControl  out  ALUW  ALU operation
- Shift  out  1  route shifter result
- Illegal  out  1  one-cycle pulse on unimplemented instruction
- Flags  out  4  registered NZCV

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=ADD. Held MEM_LAT cycles (wait counter). IRWrite and PCWrite assert only on the final cycle. Then → DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10 (PC+8 read). CondEx evaluated from Cond and Flags. If CondEx=0 → FETCH. Otherwise Op=00 → EXECI if Funct[5], else EXECR. Op=01 → MEMADR. Op=10 → BRANCH. Op=11 or unknown DP Funct[4:1] → FETCH with Illegal=1.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ADD. Goes to MEMRD if Funct[0] (LDR), else MEMWR.
- MEMRD: AdrSrc=1. Held MEM_LAT cycles, then → MEMWB. MEMWB: ResultSrc=01, then → FETCH.
- MEMWR: AdrSrc=1, MemW=1 for exactly one cycle, then → FETCH.
- EXECR/EXECI: ALUSrcA=0, ALUSrcB=00/01, ALU op from Funct[4:1]. Then → ALUWB. ALUWB: ResultSrc=00, then → FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, PCWrite=1, ImmSrc=10, then → FETCH.
- ALU decode, Funct[4:1] → ALUControl:
  - 0100 ADD=000; 0010 SUB=001; 0000 AND=010; 1100 ORR=011; 0001 EOR=100.
  - 1010 CMP: SUB with NoWrite.
  - 1101 MOV/LSL/LSR: 101, Shift=1.
  - Upper bits beyond 3 are zero.
- Writeback (MEMWB/ALUWB): RegW=1 unless NoWrite or Rd=1111. If Rd=1111 then PCWrite=1 instead and RegW=0.
- Flags update in the EXEC cycle when Funct[0]=1 and the instruction is DP:
  - N,Z always.
  - C,V only for ADD/SUB/CMP.
  - Shift ops update N,Z only.
- Conditions: standard ARM EQ…LE, 1110=AL. 1111 treated as never-execute.
- RegSrc: bit0=1 for BRANCH; bit1=1 for STR (both DECODE and MEMWR).
- ImmSrc: 00 DP, 01 mem, 10 branch.

## Timing
- Reset (synchronous):
  - State←FETCH, wait counter←0, Flags←0000.
  - While reset=1, PCWrite/IRWrite/RegW/MemW/Illegal forced 0.
  - First fetch begins on the first cycle after reset is deasserted.
- Reset asserted mid-instruction aborts it; no write enable asserts in that cycle.
- Cycle counts with MEM_LAT=L:
  - DP: L+3.
  - LDR: 2L+3.
  - STR: L+3.
  - B: L+2.
  - Condition-fail or illegal: L+1.
- All outputs are a Moore decode of state, plus counter-final qualification and the registered Flags. No combinational path from ALUFlags to outputs.
- Flags change on the clock edge ending the EXEC cycle. A condition on the next instruction sees the new value.

## Structure
- Package ctrl_pkg holds:
  - state enum;
  - ALU opcode constants;
  - condition-code constants;
  - ImmSrc/ResultSrc encodings.
- Sub-module cond_check: combinational (Cond, Flags) → CondEx. Instanced once.
- The FSM, wait counter and flags register live in multicycle_ctrl.

## Test plan
- Reset held 3 cycles, then ADD R1,R2,R3 with L=1: state FETCH→DECODE→EXECR→ALUWB. RegW=1 only in cycle 4. Flags stay 0000.
- SUBS giving ALUFlags=0110 (Z,C), then BEQ: Flags=0110. Branch taken with PCWrite in the BRANCH cycle. A following BNE returns to FETCH after DECODE.
- LDR with MEM_LAT=3:
  - IRWrite high only in cycle 3.
  - MEMRD lasts 3 cycles.
  - Total 9 cycles.
  - RegW in MEMWB.
- STR: MemW=1 for exactly 1 cycle, RegSrc[1]=1. ADD with Rd=1111: PCWrite=1, RegW=0 in ALUWB.
- Funct[4:1]=0111: Illegal pulses 1 cycle in DECODE, then FETCH. Op=11 gives the same.
- Reset asserted during MEMRD: next cycle is FETCH, MemW=RegW=0, Flags=0000.
